mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the datapath's MAR/MDR memory interface. It samples the control unit's `Read` and `write_mem` strobes, performs the access on an internal word-addressed RAM after a programmable wait, and returns read data for MDR capture. While an access is pending it drives `busy`, which the top level wires to the control unit's `stop` input to freeze the state machine.

## Interface
- `ADDR_W`, 9 — RAM address width; the RAM depth is 2^ADDR_W words.
- `WAIT_CYCLES`, 2 — extra wait cycles per access; legal range 0–15.
- `WP_LIMIT`, 64 — first writable word address when `MEM_WP_EN` is defined.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `read_req`  in  1  level strobe from the control unit `Read`.
- `write_req`  in  1  level strobe from the control unit `write_mem`.
- `addr`  in  32  word address from MAR.
- `wdata`  in  32  write data from MDR.
- `rdata`  out  32  registered read data, to the MDR input mux.
- `rdata_valid`  out  1  one-cycle pulse; `rdata` was updated this cycle.
- `busy`  out  1  access pending; drives `stop`.
- `done`  out  1  one-cycle pulse on completion of any access, read or write.
- `err`  out  1  one-cycle pulse: address out of range, or conflicting strobes.
- `wp_fault`  out  1  one-cycle pulse: write was blocked. Tied to 0 when `MEM_WP_EN` is not defined.

## Operation
- **Edge detect.** Registers `rd_q`/`wr_q` hold the previous-cycle strobes. A request is a 0→1 transition, `read_req & ~rd_q` or `write_req & ~wr_q`. Holding a strobe high never re-triggers an access.
- **States.** IDLE, WAIT, DONE. `busy = (state == WAIT)`.
- **IDLE.**
  - Single rising edge: latch `addr`, `wdata` and the access type; load `cnt = WAIT_CYCLES`; go to WAIT.
  - Both strobes rise in the same cycle: no access is made; `err` pulses next cycle; stay in IDLE.
- **WAIT.**
  - `cnt != 0`: decrement `cnt`.
  - `cnt == 0`: perform the access at the clock edge and go to DONE.
  - Strobe edges in WAIT or DONE are ignored, but `rd_q`/`wr_q` keep tracking the inputs.
- **DONE.** Lasts one cycle.
  - `done` is high.
  - For a read, `rdata_valid` is high.
  - `err` and `wp_fault` are high if applicable.
  - Next state is IDLE.
- **Range check.** An address is out of range if any bit of `addr[31:ADDR_W]` is set.
  - Read: `rdata` loads 0.
  - Write: dropped.
  - `err` pulses in DONE in both cases.
- **Data hold.**
  - `rdata` holds its value until the next read completes; writes never modify it.
  - A read immediately after a write to the same address returns the new data.
- **Reset.**
  - `state` = IDLE; `cnt`, `rd_q`, `wr_q` = 0.
  - All outputs are 0: `rdata` 0, `rdata_valid` 0, `busy` 0, `done` 0, `err` 0, `wp_fault` 0.
  - RAM contents are retained.
  - An access in flight is abandoned and no write occurs.
  - A strobe already high when reset deasserts counts as a new edge on the first post-reset cycle, because `rd_q`/`wr_q` were cleared.

## Timing
- Request edge visible in cycle k.
- `busy` high in cycles k+1 … k+1+WAIT_CYCLES.
- DONE in cycle k+2+WAIT_CYCLES: `rdata` is updated and `rdata_valid`/`done` are high.
- `busy` is low in DONE, so the controller resumes on that cycle and can capture MDR.
- With WAIT_CYCLES=0: `busy` is high for one cycle and DONE falls at k+2.
- Total occupancy is WAIT_CYCLES+2 cycles; the next request is accepted no earlier than the cycle after DONE.

## Configuration
- `MEM_WP_EN` defined:
  - In-range writes with address < WP_LIMIT are not performed.
  - `wp_fault` pulses in DONE; `done` still pulses and `err` stays low.
  - Reads are unaffected.
- `MEM_WP_EN` undefined: no write protection, and `wp_fault` is constant 0.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x80, then read 0x80. Response with WAIT_CYCLES=2: `busy` high 3 cycles; `rdata`=0xDEADBEEF with `rdata_valid` at k+4; `done` pulses once for each access.
- Hold `read_req` high for 10 cycles at address 0x10. Exactly one access occurs; `busy` is high only 3 cycles.
- Raise `read_req` and `write_req` in the same cycle. `err` pulses; RAM is unchanged; `busy` stays 0; `rdata` keeps its old value.
- Read address 0x0000_0200 with ADDR_W=9. `rdata`=0 with `rdata_valid` and `err`. A write to 0x200 is dropped and does not alias onto address 0.
- Assert `reset` during WAIT of a write to 0x90 holding 0x1234. Outputs go to 0 next cycle; a later read of 0x90 returns the prior contents. With `read_req` held through reset, a read starts on the first post-reset cycle.
- With `MEM_WP_EN` defined, write 0x55 to address 0x3F, then 0xAA to 0x40. The first write gives `wp_fault`=1 and leaves memory unchanged; the second gives `wp_fault`=0, and reading 0x40 returns 0xAA.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface: edge-triggered accesses to an
// internal word RAM after WAIT_CYCLES wait states. Define MEM_WP_EN for write protection.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2,
  parameter int WP_LIMIT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        wp_fault
);

`ifdef MEM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_rd_q, r_wr_q;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_wdata;
  logic        r_is_wr;
  logic [31:0] r_rdata;
  logic        r_rdata_valid, r_done, r_err, r_wp;
  logic [31:0] r_mem [2**ADDR_W];

  logic w_rd_edge, w_wr_edge, w_start, w_conflict, w_fire;
  logic w_oor, w_wp_hit, w_mem_we;

  assign w_rd_edge  = read_req  & ~r_rd_q;
  assign w_wr_edge  = write_req & ~r_wr_q;
  assign w_start    = (r_state == S_IDLE) & (w_rd_edge ^ w_wr_edge);
  assign w_conflict = (r_state == S_IDLE) & w_rd_edge & w_wr_edge;
  assign w_fire     = (r_state == S_WAIT) & (r_cnt == '0);
  assign w_oor      = |r_addr[31:ADDR_W];
  assign w_wp_hit   = WP_EN & ~w_oor & (r_addr < 32'(WP_LIMIT));
  // Reset gates the RAM write so an access caught in its final wait cycle is abandoned.
  assign w_mem_we   = ~reset & w_fire & r_is_wr & ~w_oor & ~w_wp_hit;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_q        <= 1'b0;
      r_wr_q        <= 1'b0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_is_wr       <= 1'b0;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_wp          <= 1'b0;
    end else begin
      r_rd_q        <= read_req;
      r_wr_q        <= write_req;
      r_done        <= w_fire;
      r_rdata_valid <= w_fire & ~r_is_wr;
      r_err         <= w_conflict | (w_fire & w_oor);
      r_wp          <= w_fire & r_is_wr & w_wp_hit;
      if (w_start) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_is_wr <= w_wr_edge;
        r_cnt   <= 4'(WAIT_CYCLES);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_fire && !r_is_wr)
        r_rdata <= w_oor ? '0 : r_mem[r_addr[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr[ADDR_W-1:0]] <= r_wdata;
  end

  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;
  assign busy        = (r_state == S_WAIT);
  assign done        = r_done;
  assign err         = r_err;
  assign wp_fault    = WP_EN ? r_wp : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reference RAM model plus read-data scoreboard.
// Expected write-protect behaviour follows the MEM_WP_EN macro.
module tb_mem_responder;

  localparam int WAITC = 2;
`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_req = 1'b0, write_req = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        rdata_valid, busy, done, err, wp_fault;

  int          n_asserts = 0;
  int          n_fail = 0;
  logic [31:0] model [512];
  logic [31:0] sb [$];
  logic [31:0] last_rd = '0;

  mem_responder #(.ADDR_W(9), .WAIT_CYCLES(WAITC), .WP_LIMIT(64)) dut (
    .clk(clk), .reset(reset), .read_req(read_req), .write_req(write_req),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .busy(busy), .done(done), .err(err), .wp_fault(wp_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: strobe held for 'hold' cycles, outputs observed over a fixed window.
  task automatic access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                        input int hold, input bit rel_rst, input string tag);
    int busy_n = 0, done_n = 0, err_n = 0, wp_n = 0, rv_n = 0, done_at = -1;
    logic [31:0] rd = '0;
    logic [31:0] exp_rd;
    bit oor    = (a[31:9] != 23'd0);
    bit wp_hit = WP_ON && !oor && (a < 32'd64);
    if (!is_wr) sb.push_back(oor ? 32'd0 : model[a[8:0]]);
    else if (!oor && !wp_hit) model[a[8:0]] = d;
    @(negedge clk);
    if (rel_rst) reset = 1'b0;
    addr = a;
    wdata = d;
    if (is_wr) write_req = 1'b1; else read_req = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == hold) begin read_req = 1'b0; write_req = 1'b0; end
      if (busy) busy_n++;
      if (err) err_n++;
      if (wp_fault) wp_n++;
      if (rdata_valid) rv_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin done_at = i; rd = rdata; end
      end
    end
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'(WAITC + 1));
    chk({tag, "_done_count"}, 32'(done_n), 32'd1);
    chk({tag, "_done_cycle"}, 32'(done_at), 32'(WAITC + 2));
    chk({tag, "_err_count"}, 32'(err_n), {31'd0, oor});
    chk({tag, "_wp_count"}, 32'(wp_n), {31'd0, is_wr & wp_hit});
    chk({tag, "_rvalid_count"}, 32'(rv_n), {31'd0, !is_wr});
    if (!is_wr) begin
      exp_rd = sb.pop_front();
      chk({tag, "_rdata"}, rd, exp_rd);
      last_rd = exp_rd;
    end
    chk({tag, "_rdata_hold"}, rdata, last_rd);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", {27'd0, rdata_valid, busy, done, err, wp_fault}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // basic write then read, plus setup data
    access(1'b1, 32'h80, 32'hDEADBEEF, 1, 1'b0, "wr80");
    access(1'b0, 32'h80, 32'h0, 1, 1'b0, "rd80");
    access(1'b1, 32'h10, 32'h10101010, 1, 1'b0, "wr10");
    access(1'b1, 32'h44, 32'hA5A50000, 1, 1'b0, "wr44");

    // held strobe triggers only once
    access(1'b0, 32'h10, 32'h0, 10, 1'b0, "rd10_hold");

    // conflicting strobes
    @(negedge clk);
    addr = 32'h80; wdata = 32'h12345678; read_req = 1'b1; write_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0; write_req = 1'b0;
    chk("conf_err", {31'd0, err}, 32'd1);
    chk("conf_busy", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    chk("conf_err_clear", {31'd0, err}, 32'd0);
    chk("conf_rdata", rdata, last_rd);
    repeat (4) begin
      @(negedge clk);
      chk("conf_idle", {30'd0, busy, done}, 32'd0);
    end
    access(1'b0, 32'h80, 32'h0, 1, 1'b0, "rd80_after_conf");

    // out-of-range read/write, no aliasing
    access(1'b0, 32'h200, 32'h0, 1, 1'b0, "rd200");
    access(1'b1, 32'h244, 32'h0BAD0BAD, 1, 1'b0, "wr244");
    access(1'b0, 32'h44, 32'h0, 1, 1'b0, "rd44_alias");

    // reset during final wait cycle of a write
    access(1'b1, 32'h90, 32'h00001111, 1, 1'b0, "wr90_a");
    @(negedge clk);
    addr = 32'h90; wdata = 32'h00001234; write_req = 1'b1;
    @(negedge clk);
    write_req = 1'b0;
    chk("inflight_busy1", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    chk("inflight_busy3", {31'd0, busy}, 32'd1);
    reset = 1'b1; read_req = 1'b1;
    @(negedge clk);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_flags", {27'd0, rdata_valid, busy, done, err, wp_fault}, 32'd0);
    last_rd = 32'd0;
    access(1'b0, 32'h90, 32'h0, 2, 1'b1, "rd90_post_rst");

    // write-protect boundary
    access(1'b1, 32'h3F, 32'h55, 1, 1'b0, "wr3f");
    access(1'b1, 32'h40, 32'hAA, 1, 1'b0, "wr40");
    access(1'b0, 32'h3F, 32'h0, 1, 1'b0, "rd3f");
    access(1'b0, 32'h40, 32'h0, 1, 1'b0, "rd40");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
